cam_stream_gen: RTL and testbench

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

---
 rtl/cam_pkg.sv | 65 ++++++
 rtl/cam_pattern_gen.sv | 39 +++
 rtl/cam_stream_gen.sv | 135 +++++++++++++
 tb/tb_cam_stream_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared constants, types and helpers for the camera test-stream generator.
package cam_pkg;

  localparam int unsigned CAM_SCREEN_X_DEF = 160;
  localparam int unsigned CAM_SCREEN_Y_DEF = 120;
  localparam int unsigned H_BLANK_DEF      = 16;
  localparam int unsigned VSYNC_LINES_DEF  = 3;
  localparam int unsigned V_BACK_DEF       = 2;
  localparam int unsigned V_FRONT_DEF      = 2;

  localparam int unsigned PIX_W = 16;
  localparam int unsigned PAT_W = 3;

  localparam logic [PIX_W-1:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [PIX_W-1:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [PIX_W-1:0] RGB_CYAN    = 16'h07FF;
  localparam logic [PIX_W-1:0] RGB_GREEN   = 16'h07E0;
  localparam logic [PIX_W-1:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [PIX_W-1:0] RGB_RED     = 16'hF800;
  localparam logic [PIX_W-1:0] RGB_BLUE    = 16'h001F;
  localparam logic [PIX_W-1:0] RGB_BLACK   = 16'h0000;

  localparam logic [PAT_W-1:0] PAT_RED   = 3'd0;
  localparam logic [PAT_W-1:0] PAT_GREEN = 3'd1;
  localparam logic [PAT_W-1:0] PAT_BLUE  = 3'd2;
  localparam logic [PAT_W-1:0] PAT_BARS  = 3'd3;
  localparam logic [PAT_W-1:0] PAT_GRAD  = 3'd4;
  localparam logic [PAT_W-1:0] PAT_CHECK = 3'd5;
  localparam logic [PAT_W-1:0] PAT_RAMP  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } cam_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Colour-bar palette, left to right.
  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
    logic [PIX_W-1:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern source: (x, y, pattern) -> RGB565 pixel.
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int unsigned CAM_SCREEN_X = CAM_SCREEN_X_DEF
) (
  input  logic [PIX_W-1:0] i_x,
  input  logic [PIX_W-1:0] i_y,
  input  logic [PAT_W-1:0] i_pattern,
  output logic [PIX_W-1:0] o_pixel_c
);

  localparam int unsigned BAR_W = (CAM_SCREEN_X >= 8) ? CAM_SCREEN_X / 8 : 1;

  logic [PIX_W-1:0] w_bar_idx;
  logic [2:0]       w_bar;
  rgb565_t          w_grad;
  logic [PIX_W-1:0] w_ramp;

  always_comb begin
    w_bar_idx = i_x / PIX_W'(BAR_W);
    // Leftover columns when the width is not a multiple of 8 stay in the last bar.
    w_bar     = (w_bar_idx > PIX_W'(7)) ? 3'd7 : w_bar_idx[2:0];
    w_grad    = '{r: i_x[7:3], g: i_y[6:1], b: 5'd0};
    w_ramp    = i_y * PIX_W'(CAM_SCREEN_X) + i_x;

    o_pixel_c = w_ramp;
    case (i_pattern)
      PAT_RED:   o_pixel_c = RGB_RED;
      PAT_GREEN: o_pixel_c = RGB_GREEN;
      PAT_BLUE:  o_pixel_c = RGB_BLUE;
      PAT_BARS:  o_pixel_c = bar_color(w_bar);
      PAT_GRAD:  o_pixel_c = w_grad;
      PAT_CHECK: o_pixel_c = (i_x[3] ^ i_y[3]) ? RGB_WHITE : RGB_BLACK;
      default:   o_pixel_c = w_ramp;
    endcase
  end

endmodule

// File: rtl/cam_stream_gen.sv
// Camera-style frame generator: vsync/href timing FSM plus RGB565 byte stream.
module cam_stream_gen
  import cam_pkg::*;
#(
  parameter int unsigned CAM_SCREEN_X = CAM_SCREEN_X_DEF,
  parameter int unsigned CAM_SCREEN_Y = CAM_SCREEN_Y_DEF,
  parameter int unsigned H_BLANK      = H_BLANK_DEF,
  parameter int unsigned VSYNC_LINES  = VSYNC_LINES_DEF,
  parameter int unsigned V_BACK       = V_BACK_DEF,
  parameter int unsigned V_FRONT      = V_FRONT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PAT_W-1:0] pattern,
  output logic             pclk,
  output logic             vsync,
  output logic             href,
  output logic [7:0]       px_data,
  output logic             frame_done
);

  localparam int unsigned ACT_CLKS  = 2 * CAM_SCREEN_X;
  localparam int unsigned LINE_CLKS = ACT_CLKS + H_BLANK;
  localparam int unsigned HW        = $clog2(LINE_CLKS);
  localparam int unsigned MAX_LINES = max_u(max_u(CAM_SCREEN_Y, VSYNC_LINES),
                                            max_u(V_BACK, V_FRONT));
  localparam int unsigned LW        = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  cam_state_e       r_state;
  logic [HW-1:0]    r_hcnt;
  logic [LW-1:0]    r_lcnt;
  logic [PAT_W-1:0] r_pattern;
  logic             r_vsync;
  logic             r_href;
  logic [7:0]       r_px_data;
  logic             r_frame_done;

  cam_state_e       w_nstate;
  logic [HW-1:0]    w_nh;
  logic [LW-1:0]    w_nl;
  logic [LW-1:0]    w_last_line;
  logic             w_latch;
  logic             w_href_n;
  logic             w_done_n;
  logic [PIX_W-1:0] w_pixel;

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    w_nstate = r_state;
    w_nh     = r_hcnt;
    w_nl     = r_lcnt;
    w_latch  = 1'b0;

    case (r_state)
      ST_VSYNC:  w_last_line = LW'(VSYNC_LINES - 1);
      ST_VBACK:  w_last_line = LW'(V_BACK - 1);
      ST_ACTIVE: w_last_line = LW'(CAM_SCREEN_Y - 1);
      default:   w_last_line = LW'(V_FRONT - 1);
    endcase

    if (r_state == ST_IDLE) begin
      w_nh = '0;
      w_nl = '0;
      if (enable) begin
        w_nstate = ST_VSYNC;
        w_latch  = 1'b1;
      end
    end else if (r_hcnt == HW'(LINE_CLKS - 1)) begin
      w_nh = '0;
      if (r_lcnt == w_last_line) begin
        w_nl = '0;
        case (r_state)
          ST_VSYNC:  w_nstate = ST_VBACK;
          ST_VBACK:  w_nstate = ST_ACTIVE;
          ST_ACTIVE: w_nstate = ST_VFRONT;
          ST_VFRONT: begin
            w_nstate = enable ? ST_VSYNC : ST_IDLE;
            w_latch  = enable;
          end
          default:   w_nstate = ST_IDLE;
        endcase
      end else begin
        w_nl = r_lcnt + LW'(1);
      end
    end else begin
      w_nh = r_hcnt + HW'(1);
    end

    w_href_n = (w_nstate == ST_ACTIVE) && (w_nh < HW'(ACT_CLKS));
    w_done_n = (w_nstate == ST_VFRONT) && (w_nl == LW'(V_FRONT - 1)) &&
               (w_nh == HW'(LINE_CLKS - 1));
  end

  cam_pattern_gen #(
    .CAM_SCREEN_X(CAM_SCREEN_X)
  ) u_pattern (
    .i_x      (PIX_W'(w_nh >> 1)),
    .i_y      (PIX_W'(w_nl)),
    .i_pattern(r_pattern),
    .o_pixel_c(w_pixel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_hcnt       <= '0;
      r_lcnt       <= '0;
      r_pattern    <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_px_data    <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_hcnt       <= w_nh;
      r_lcnt       <= w_nl;
      if (w_latch) begin
        r_pattern <= pattern;
      end
      r_vsync      <= (w_nstate == ST_VSYNC);
      r_href       <= w_href_n;
      // High byte on even cycles of a pixel pair, low byte on odd.
      r_px_data    <= w_href_n ? (w_nh[0] ? w_pixel[7:0] : w_pixel[15:8]) : 8'h00;
      r_frame_done <= w_done_n;
    end
  end

  assign pclk       = ~clk;
  assign vsync      = r_vsync;
  assign href       = r_href;
  assign px_data    = r_px_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen at default 160x120 timing.
module tb_cam_stream_gen;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] pattern;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] px_data;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  int vs_cnt, vs_last, first_href, href_pulses, bad_runs, fd_cnt, fd_cyc, low_nz;
  logic [7:0] bytes_q[$];

  cam_stream_gen dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pattern   (pattern),
    .pclk      (pclk),
    .vsync     (vsync),
    .href      (href),
    .px_data   (px_data),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe n_cyc cycles (cycle 1 = first cycle after the frame-start edge).
  task automatic watch(input int n_cyc, input int pat_at, input logic [2:0] pat_val,
                       input int en_at);
    logic prev_href;
    int   run;
    vs_cnt = 0; vs_last = 0; first_href = 0; href_pulses = 0; bad_runs = 0;
    fd_cnt = 0; fd_cyc = 0; low_nz = 0; run = 0; prev_href = 1'b0;
    bytes_q.delete();
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      if (vsync) begin
        vs_cnt++;
        vs_last = c;
      end
      if (href) begin
        if (!prev_href) begin
          href_pulses++;
          if (first_href == 0) first_href = c;
        end
        run++;
        bytes_q.push_back(px_data);
      end else begin
        if (prev_href && run != 320) bad_runs++;
        run = 0;
        if (px_data != 8'h00) low_nz++;
      end
      prev_href = href;
      if (frame_done) begin
        fd_cnt++;
        if (fd_cyc == 0) fd_cyc = c;
      end
      if (c == pat_at) pattern = pat_val;
      if (c == en_at) enable = 1'b0;
    end
  endtask

  task automatic check_pix(input string tag, input int x, input int y, input logic [15:0] exp);
    int idx;
    idx = 2 * (y * 160 + x);
    check({tag, "_hi"}, 32'(bytes_q[idx]), 32'(exp[15:8]));
    check({tag, "_lo"}, 32'(bytes_q[idx+1]), 32'(exp[7:0]));
  endtask

  initial begin
    int errs;
    rst = 1'b0; enable = 1'b0; pattern = 3'd0;

    @(negedge clk);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_href", 32'(href), 32'd0);
    check("rst_px", 32'(px_data), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("pclk_inv", 32'(pclk), 32'd1);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_vsync", 32'(vsync), 32'd0);

    // Frame A: ramp, pattern flipped mid-frame, enable dropped during line 60.
    pattern = 3'd6; enable = 1'b1;
    watch(43000, 20000, 3'd0, 21900);
    check("a_vsync_clks", vs_cnt, 1008);
    check("a_vsync_last", vs_last, 1008);
    check("a_first_href", first_href, 1681);
    check("a_href_pulses", href_pulses, 120);
    check("a_bad_runs", bad_runs, 0);
    check("a_nbytes", bytes_q.size(), 38400);
    check("a_done_cnt", fd_cnt, 1);
    check("a_done_cyc", fd_cyc, 42672);
    check("a_low_nz", low_nz, 0);
    check_pix("a_p1_0", 1, 0, 16'h0001);
    check_pix("a_p0_1", 0, 1, 16'h00A0);
    check_pix("a_p100_100", 100, 100, 16'h3EE4);
    check_pix("a_p159_119", 159, 119, 16'h4AFF);

    // Frame B: solid red, reset during line 30.
    enable = 1'b1;
    watch(11801, 0, 3'd0, 0);
    check("b_vsync_clks", vs_cnt, 1008);
    check("b_first_href", first_href, 1681);
    check("b_href_pulses", href_pulses, 31);
    check("b_bad_runs", bad_runs, 0);
    errs = 0;
    for (int i = 0; i < bytes_q.size(); i++) begin
      if (bytes_q[i] != ((i % 2 == 0) ? 8'hF8 : 8'h00)) errs++;
    end
    check("b_bytes_bad", errs, 0);
    check("b_href_before", 32'(href), 32'd1);
    check("b_px_before", 32'(px_data), 32'hF8);
    rst = 1'b0;
    #1;
    check("b_rst_href", 32'(href), 32'd0);
    check("b_rst_vsync", 32'(vsync), 32'd0);
    check("b_rst_px", 32'(px_data), 32'd0);
    check("b_rst_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    check("b_rst_hold", 32'(vsync), 32'd0);

    // Frame C: colour bars, fresh frame after reset release.
    pattern = 3'd3;
    rst = 1'b1;
    watch(2400, 0, 3'd0, 0);
    check("c_vsync_clks", vs_cnt, 1008);
    check("c_vsync_last", vs_last, 1008);
    check("c_first_href", first_href, 1681);
    check_pix("c_x0", 0, 0, 16'hFFFF);
    check_pix("c_x19", 19, 0, 16'hFFFF);
    check_pix("c_x20", 20, 0, 16'hFFE0);
    check_pix("c_x100", 100, 0, 16'hF800);
    check_pix("c_x140", 140, 0, 16'h0000);
    check_pix("c_x159", 159, 0, 16'h0000);

    // Frame D: checkerboard after a second reset.
    rst = 1'b0; pattern = 3'd5;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    watch(4800, 0, 3'd0, 0);
    check("d_first_href", first_href, 1681);
    check_pix("d_p0_0", 0, 0, 16'h0000);
    check_pix("d_p8_0", 8, 0, 16'hFFFF);
    check_pix("d_p0_8", 0, 8, 16'hFFFF);
    check_pix("d_p8_8", 8, 8, 16'h0000);

    enable = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
